// File: rtl/rgb_pwm_pkg.sv
// -----------------------------------------------------------------------------
// rgb_pwm_pkg
// Shared definitions for the RGB LED PWM controller: register offsets, CTRL
// field positions, the PWM counter wrap value and the DUTY byte lane assigned
// to each colour channel.
// -----------------------------------------------------------------------------
package rgb_pwm_pkg;

    localparam int PWM_BITS = 8;

    // Last value of the PWM counter. The counter runs 0..254, so a duty of 255
    // keeps the output high for the whole period.
    localparam logic [PWM_BITS-1:0] PWM_MAX = 8'd254;

    // Register offsets, decoded from iomem_addr[3:2].
    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_DUTY   = 2'd1,
        REG_FADE   = 2'd2,
        REG_STATUS = 2'd3
    } reg_off_e;

    // CTRL field positions.
    localparam int CTRL_ENABLE_BIT   = 0;
    localparam int CTRL_FADE_EN_BIT  = 1;
    localparam int CTRL_PRESCALE_LSB = 8;

    // Byte lane of each channel inside DUTY and STATUS.
    localparam int LANE_B = 0;
    localparam int LANE_G = 1;
    localparam int LANE_R = 2;

    typedef struct packed {
        logic [7:0] prescale;
        logic       fade_en;
        logic       enable;
    } ctrl_t;

    // Replace one byte only when its write strobe is set.
    function automatic logic [7:0] merge_byte(input logic [7:0] old_val,
                                              input logic [7:0] new_val,
                                              input logic       strobe);
        return strobe ? new_val : old_val;
    endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// -----------------------------------------------------------------------------
// rgb_pwm_channel
// One colour channel. It holds the current duty, which changes only at a PWM
// period boundary, and compares it with the shared counter to drive the
// channel's PWM output.
//
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   cnt_i         shared PWM counter (0..PWM_MAX)
//   boundary_i    last tick of a PWM period
//   fade_step_i   boundary on which a faded channel moves one step
//   fade_en_i     1 = ramp toward the target, 0 = jump to it
//   enable_i      controller enable
//   target_i      target duty taken from the DUTY register
//   cur_o         current duty
//   pwm_o         registered PWM output
//   busy_o        current duty differs from the target
// -----------------------------------------------------------------------------
module rgb_pwm_channel
    import rgb_pwm_pkg::*;
#(
    parameter int W = PWM_BITS
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] cnt_i,
    input  logic         boundary_i,
    input  logic         fade_step_i,
    input  logic         fade_en_i,
    input  logic         enable_i,
    input  logic [W-1:0] target_i,
    output logic [W-1:0] cur_o,
    output logic         pwm_o,
    output logic         busy_o
);

    logic [W-1:0] cur_q, cur_d;
    logic         pwm_q, pwm_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cur_d = cur_q;
        pwm_d = enable_i && (cnt_i < cur_q);

        if (!enable_i) begin
            // Track the target while disabled so that re-enabling starts at it.
            cur_d = target_i;
        end else if (boundary_i) begin
            if (!fade_en_i) begin
                cur_d = target_i;
            end else if (fade_step_i) begin
                // Move one step toward the target; equality stops the ramp,
                // so it never overshoots.
                if (cur_q < target_i) begin
                    cur_d = cur_q + 1'b1;
                end else if (cur_q > target_i) begin
                    cur_d = cur_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cur_q <= cur_d;
            pwm_q <= pwm_d;
        end
    end

    assign cur_o  = cur_q;
    assign pwm_o  = pwm_q;
    assign busy_o = (cur_q != target_i);

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// rgb_pwm_ctrl
// Memory-mapped RGB LED PWM controller on the PicoSoC iomem bus. Holds the
// CTRL / DUTY / FADE registers, a prescaler, the shared PWM counter and the
// fade counter, and instantiates one rgb_pwm_channel per colour.
//
// Ports:
//   clk, resetn     clock, synchronous active-low reset
//   iomem_valid     bus request valid
//   iomem_ready     one-cycle acknowledge, the cycle after selection
//   iomem_wstrb     byte write strobes, 0 = read
//   iomem_addr      byte address; [31:24] selects the block, [3:2] the register
//   iomem_wdata     write data
//   iomem_rdata     registered read data, valid with iomem_ready
//   pwm_r/g/b       PWM outputs to the RGB driver
// -----------------------------------------------------------------------------
module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter logic [7:0] ADDR_SEL = 8'h04
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        pwm_r,
    output logic        pwm_g,
    output logic        pwm_b
);

    // ---------------------------------------------------------------- state
    ctrl_t                    ctrl_q, ctrl_d;
    logic [3*PWM_BITS-1:0]    duty_q, duty_d;
    logic [15:0]              fade_q, fade_d;
    logic                     ready_q, ready_d;
    logic [31:0]              rdata_q, rdata_d;

    logic [7:0]               pre_q, pre_d;
    logic [PWM_BITS-1:0]      cnt_q, cnt_d;
    logic [15:0]              fcnt_q, fcnt_d;

    logic                     sel;
    logic                     wr_en;
    reg_off_e                 reg_off;
    logic                     tick;
    logic                     boundary;
    logic                     fade_step;

    logic [PWM_BITS-1:0]      cur_r, cur_g, cur_b;
    logic                     busy_r, busy_g, busy_b;
    logic                     busy;

    // Address bits outside the decode, and the unused top write byte.
    logic                     unused_bits;
    assign unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:24]};

    // ------------------------------------------------------------ bus decode
    // Masking with ready_q keeps a request that stays valid through its
    // acknowledge from being accepted twice.
    assign sel     = iomem_valid && !ready_q && (iomem_addr[31:24] == ADDR_SEL);
    assign wr_en   = sel && (iomem_wstrb != 4'b0000);
    assign reg_off = reg_off_e'(iomem_addr[3:2]);

    // ------------------------------------------------------------- timebase
    assign tick      = ctrl_q.enable && (pre_q == ctrl_q.prescale);
    assign boundary  = tick && (cnt_q == PWM_MAX);
    assign fade_step = boundary && ctrl_q.fade_en && (fcnt_q == fade_q);

    always_comb begin
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        fcnt_d = fcnt_q;

        if (!ctrl_q.enable) begin
            pre_d  = '0;
            cnt_d  = '0;
            fcnt_d = '0;
        end else begin
            // Compared with ==, so a prescale written below the running count
            // only takes effect after the counter wraps past 255.
            pre_d = tick ? 8'd0 : pre_q + 8'd1;

            if (tick) begin
                cnt_d = (cnt_q == PWM_MAX) ? '0 : cnt_q + 1'b1;
            end

            if (boundary && ctrl_q.fade_en) begin
                fcnt_d = (fcnt_q == fade_q) ? 16'd0 : fcnt_q + 16'd1;
            end
        end
    end

    // -------------------------------------------------------- register file
    always_comb begin
        ctrl_d  = ctrl_q;
        duty_d  = duty_q;
        fade_d  = fade_q;
        ready_d = sel;
        rdata_d = rdata_q;

        if (wr_en) begin
            unique case (reg_off)
                REG_CTRL: begin
                    if (iomem_wstrb[0]) begin
                        ctrl_d.enable  = iomem_wdata[CTRL_ENABLE_BIT];
                        ctrl_d.fade_en = iomem_wdata[CTRL_FADE_EN_BIT];
                    end
                    ctrl_d.prescale = merge_byte(ctrl_q.prescale,
                                                 iomem_wdata[CTRL_PRESCALE_LSB +: 8],
                                                 iomem_wstrb[1]);
                end
                REG_DUTY: begin
                    for (int lane = 0; lane < 3; lane++) begin
                        duty_d[lane*8 +: 8] = merge_byte(duty_q[lane*8 +: 8],
                                                         iomem_wdata[lane*8 +: 8],
                                                         iomem_wstrb[lane]);
                    end
                end
                REG_FADE: begin
                    fade_d[7:0]  = merge_byte(fade_q[7:0],  iomem_wdata[7:0],  iomem_wstrb[0]);
                    fade_d[15:8] = merge_byte(fade_q[15:8], iomem_wdata[15:8], iomem_wstrb[1]);
                end
                REG_STATUS: begin
                    // Read-only.
                end
            endcase
        end

        // Read data is captured on every accepted request; a write returns the
        // register's value from before the write.
        if (sel) begin
            unique case (reg_off)
                REG_CTRL:   rdata_d = {16'h0000, ctrl_q.prescale, 6'b000000,
                                       ctrl_q.fade_en, ctrl_q.enable};
                REG_DUTY:   rdata_d = {8'h00, duty_q};
                REG_FADE:   rdata_d = {16'h0000, fade_q};
                REG_STATUS: rdata_d = {7'b0000000, busy, cur_r, cur_g, cur_b};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous; resetn is sampled on the clock edge like
        // any other input, so it needs no separate sensitivity entry.
        if (!resetn) begin
            ctrl_q  <= '0;
            duty_q  <= '0;
            fade_q  <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // register samples the values from before this edge.
            ctrl_q  <= ctrl_d;
            duty_q  <= duty_d;
            fade_q  <= fade_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // -------------------------------------------------------------- channels
    // A DUTY write in the same cycle as a boundary is not yet visible here,
    // so that boundary still applies the old target.
    rgb_pwm_channel #(.W(PWM_BITS)) u_chan_r (
        .clk         (clk),
        .resetn      (resetn),
        .cnt_i       (cnt_q),
        .boundary_i  (boundary),
        .fade_step_i (fade_step),
        .fade_en_i   (ctrl_q.fade_en),
        .enable_i    (ctrl_q.enable),
        .target_i    (duty_q[LANE_R*8 +: 8]),
        .cur_o       (cur_r),
        .pwm_o       (pwm_r),
        .busy_o      (busy_r)
    );

    rgb_pwm_channel #(.W(PWM_BITS)) u_chan_g (
        .clk         (clk),
        .resetn      (resetn),
        .cnt_i       (cnt_q),
        .boundary_i  (boundary),
        .fade_step_i (fade_step),
        .fade_en_i   (ctrl_q.fade_en),
        .enable_i    (ctrl_q.enable),
        .target_i    (duty_q[LANE_G*8 +: 8]),
        .cur_o       (cur_g),
        .pwm_o       (pwm_g),
        .busy_o      (busy_g)
    );

    rgb_pwm_channel #(.W(PWM_BITS)) u_chan_b (
        .clk         (clk),
        .resetn      (resetn),
        .cnt_i       (cnt_q),
        .boundary_i  (boundary),
        .fade_step_i (fade_step),
        .fade_en_i   (ctrl_q.fade_en),
        .enable_i    (ctrl_q.enable),
        .target_i    (duty_q[LANE_B*8 +: 8]),
        .cur_o       (cur_b),
        .pwm_o       (pwm_b),
        .busy_o      (busy_b)
    );

    assign busy = busy_r || busy_g || busy_b;

    // ---------------------------------------------------------------- outputs
    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rgb_pwm_ctrl
// Self-checking bench for rgb_pwm_ctrl. Bus reads push their expected data to
// a scoreboard queue; a monitor pops and compares whenever iomem_ready is seen.
// PWM outputs are checked by counting high cycles over whole periods.
// -----------------------------------------------------------------------------
module tb_rgb_pwm_ctrl;

    localparam logic [31:0] A_CTRL   = 32'h0400_0000;
    localparam logic [31:0] A_DUTY   = 32'h0400_0004;
    localparam logic [31:0] A_FADE   = 32'h0400_0008;
    localparam logic [31:0] A_STATUS = 32'h0400_000C;

    logic        clk;
    logic        resetn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        pwm_r, pwm_g, pwm_b;

    rgb_pwm_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .pwm_r       (pwm_r),
        .pwm_g       (pwm_g),
        .pwm_b       (pwm_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] data;
        bit          chk;
    } sb_t;

    sb_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: one scoreboard entry per acknowledge.
    always @(negedge clk) begin
        if (resetn && iomem_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_ready", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.chk) check(e.tag, iomem_rdata, e.data);
            end
        end
    end

    // Called at posedge+1. Ready must appear exactly one cycle after valid and
    // last exactly one cycle.
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [31:0] exp,
                            input bit chk, input string tag);
        sb_q.push_back('{tag, exp, chk});
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wdata = wdata;
        iomem_wstrb = wstrb;
        @(posedge clk); #1;
        check({tag, "_rdy"}, {31'd0, iomem_ready}, 32'd1);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        @(posedge clk); #1;
        check({tag, "_rdy1cyc"}, {31'd0, iomem_ready}, 32'd0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus_xfer(addr, data, 4'hF, 32'd0, 1'b0, "wr");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        bus_xfer(addr, 32'd0, 4'h0, exp, 1'b1, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(posedge clk);
        #1;
    endtask

    task automatic measure(input int n, output int hr, output int hg, output int hb);
        hr = 0; hg = 0; hb = 0;
        repeat (n) begin
            @(posedge clk); #1;
            hr += int'(pwm_r);
            hg += int'(pwm_g);
            hb += int'(pwm_b);
        end
    endtask

    function automatic logic [31:0] status_g(input int g);
        return {7'd0, (g != 4), 8'h00, 8'(g), 8'h00};
    endfunction

    initial begin
        int hr, hg, hb, t0, g;

        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'd0;
        iomem_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, iomem_ready}, 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        check("rst_pwm", {29'd0, pwm_r, pwm_g, pwm_b}, 32'd0);
        resetn = 1'b1;
        idle(1);
        rd(A_CTRL,   32'd0, "rst_ctrl");
        rd(A_DUTY,   32'd0, "rst_duty");
        rd(A_FADE,   32'd0, "rst_fade");
        rd(A_STATUS, 32'd0, "rst_status");

        // Basic write/readback and a request to another block.
        wr(A_CTRL, 32'h0000_0001);
        rd(A_CTRL, 32'h0000_0001, "ctrl_rb");
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        repeat (3) begin
            @(posedge clk); #1;
            check("foreign_rdy", {31'd0, iomem_ready}, 32'd0);
        end
        check("foreign_rdata_hold", iomem_rdata, 32'h0000_0001);
        iomem_valid = 1'b0;
        wr(A_CTRL, 32'd0);

        // Byte strobes, aliasing, read-only STATUS.
        wr(A_DUTY, 32'h0011_2233);
        bus_xfer(A_DUTY, 32'hFFFF_AAFF, 4'b0010, 32'd0, 1'b0, "wr_strb");
        rd(A_DUTY, 32'h0011_AA33, "duty_strb");
        rd(32'h04FF_FFF4, 32'h0011_AA33, "duty_alias");
        wr(A_STATUS, 32'hFFFF_FFFF);
        rd(A_STATUS, 32'h0011_AA33, "status_ro");

        // Duty: P=0, fade off.
        wr(A_DUTY, 32'h0080_0000);
        wr(A_CTRL, 32'h0000_0001);
        idle(300);
        measure(255, hr, hg, hb);
        check("duty80_r", hr, 128);
        check("duty80_gb", hg + hb, 0);
        wr(A_DUTY, 32'h00FF_0000);
        idle(520);
        measure(255, hr, hg, hb);
        check("dutyFF_r", hr, 255);
        wr(A_DUTY, 32'h0000_0000);
        idle(520);
        measure(255, hr, hg, hb);
        check("duty00_r", hr, 0);

        // Prescale P=3, B=1.
        wr(A_CTRL, 32'd0);
        wr(A_DUTY, 32'h0000_0001);
        wr(A_CTRL, 32'h0000_0301);
        idle(1100);
        measure(1020, hr, hg, hb);
        check("pre3_b", hb, 4);
        check("pre3_rg", hr + hg, 0);

        // Fade: P=0, I=1, G ramps 0->4 then back to 0.
        wr(A_CTRL, 32'd0);
        wr(A_DUTY, 32'd0);
        wr(A_FADE, 32'd1);
        wr(A_CTRL, 32'h0000_0003);
        t0 = cyc;
        wr(A_DUTY, 32'h0000_0400);
        for (int k = 1; k <= 9; k++) begin
            wait_until(t0 + 255 * k + 120);
            g = (k / 2 > 4) ? 4 : k / 2;
            rd(A_STATUS, status_g(g), "fade_up");
        end
        wr(A_DUTY, 32'd0);
        for (int k = 10; k <= 17; k++) begin
            wait_until(t0 + 255 * k + 120);
            g = 4 - (k - 8) / 2;
            if (g < 0) g = 0;
            rd(A_STATUS, {7'd0, (g != 0), 8'h00, 8'(g), 8'h00}, "fade_down");
        end

        // Reset mid-fade with pwm_r high and a request in flight.
        wr(A_CTRL, 32'd0);
        wr(A_DUTY, 32'h00FF_0000);
        wr(A_CTRL, 32'h0000_0003);
        wr(A_DUTY, 32'd0);
        idle(300);
        check("prerst_pwm_r", {31'd0, pwm_r}, 32'd1);
        rd(A_STATUS, 32'h01FF_0000, "prerst_status");
        iomem_valid = 1'b1;
        iomem_addr  = A_CTRL;
        resetn      = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_pwm", {29'd0, pwm_r, pwm_g, pwm_b}, 32'd0);
        check("rst_mid_ready", {31'd0, iomem_ready}, 32'd0);
        check("rst_mid_rdata", iomem_rdata, 32'd0);
        iomem_valid = 1'b0;
        resetn      = 1'b1;
        @(posedge clk); #1;
        check("rst_no_ready", {31'd0, iomem_ready}, 32'd0);
        rd(A_STATUS, 32'd0, "postrst_status");
        rd(A_CTRL,   32'd0, "postrst_ctrl");
        rd(A_DUTY,   32'd0, "postrst_duty");
        rd(A_FADE,   32'd0, "postrst_fade");
        idle(2);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
